inport_conditioner: RTL and testbench
=====================================

INPORT_CONDITIONER -- requirements
Module: inport_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000. It is the number of consecutive stable clk cycles required to accept a change on the ready switch; legal range is 1 or more.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-003 The block SHALL have port nReset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port sw, input, 9 bits: raw switches. sw[8] is the ready switch and sw[7:0] are data; sw is asynchronous to clk.
REQ-005 The block SHALL have port inport, output, 9 bits, feeding the processor inport. inport[8] is the conditioned ready and inport[7:0] is data.
REQ-006 The block SHALL have port readyPulse, output, 1 bit: a one-cycle strobe on acceptance of ready.

Function
REQ-007 The block SHALL pass all 9 sw bits through a 2-flop synchroniser (syncSw) before any other use; synchroniser latency is 2 edges.
REQ-008 The block SHALL implement FSM states IDLE, ARM, HELD and DISARM, plus a stability counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-009 In IDLE, the block SHALL hold inport[8]=0, hold the counter at 0, and let inport[7:0] follow syncSw[7:0] each cycle; syncSw[8]=1 moves the FSM to ARM.
REQ-010 In ARM, the block SHALL increment the counter each cycle while syncSw[8]=1. syncSw[8]=0 returns the FSM to IDLE with the counter cleared. inport[7:0] keeps following syncSw[7:0].
REQ-011 When the ARM counter reaches DEBOUNCE_CYCLES-1 with syncSw[8]=1, on that edge the block SHALL enter HELD, clear the counter, capture syncSw[7:0] into inport[7:0], set inport[8]=1, and assert readyPulse for exactly that one following cycle.
REQ-012 In HELD, the block SHALL keep inport[7:0] frozen regardless of sw[7:0] activity; syncSw[8]=0 moves the FSM to DISARM.
REQ-013 In DISARM, the block SHALL count consecutive cycles with syncSw[8]=0 and keep inport[8]=1 with data frozen. syncSw[8]=1 returns the FSM to HELD with the counter cleared and no new readyPulse.
REQ-014 When the DISARM counter reaches DEBOUNCE_CYCLES-1 with syncSw[8]=0, the block SHALL enter IDLE, clear inport[8], and resume data follow on the next cycle.
REQ-015 Latency from a raw sw[8] rising edge that stays clean to inport[8]=1 and readyPulse=1 SHALL be DEBOUNCE_CYCLES+3 edges; falling-edge latency to inport[8]=0 SHALL also be DEBOUNCE_CYCLES+3 edges.
REQ-016 A ready glitch shorter than DEBOUNCE_CYCLES synchronised cycles SHALL produce no inport[8] change and no readyPulse.
REQ-017 At most one readyPulse SHALL occur per IDLE->HELD transition; readyPulse is never asserted in consecutive cycles.
REQ-018 For DEBOUNCE_CYCLES=1, ARM and DISARM SHALL each last exactly one cycle.

Reset
REQ-019 While nReset=0, the block SHALL asynchronously force the FSM to IDLE, the counter to 0, syncSw to 0, inport to 0 and readyPulse to 0.
REQ-020 On reset release, the block SHALL start from IDLE. A switch already high goes through the full ARM sequence, with no pulse within the first DEBOUNCE_CYCLES+2 edges.
REQ-021 Reset asserted in any state, including mid-count or during readyPulse, SHALL abort the operation with no pending pulse after release.

Configuration
REQ-022 The block SHALL be controlled by macro INPORT_DEBOUNCE_EN. When it is defined, the block behaves per REQ-008..REQ-018.
REQ-023 When INPORT_DEBOUNCE_EN is undefined, the block SHALL omit the counter and the ARM/DISARM states: IDLE->HELD on syncSw[8]=1 and HELD->IDLE on syncSw[8]=0. Edge latency is 3, with capture and readyPulse as in REQ-011, and DEBOUNCE_CYCLES is ignored.

Verification (DEBOUNCE_CYCLES=4, INPORT_DEBOUNCE_EN defined unless stated)
REQ-024 Clean press: set sw=9'h0A5 then sw[8]=1 at edge 0 -> inport=9'h1A5 and readyPulse=1 at edge 7 only, with readyPulse=0 at edge 8.
REQ-025 Bounce: sw[8] high for 3 cycles, low for 2, high for 2, then low -> inport[8] stays 0 and readyPulse is never asserted.
REQ-026 Freeze: in HELD with captured 8'h3C, toggle sw[7:0] to 8'hFF -> inport[7:0] stays 8'h3C until 7 edges after sw[8] falls, then follows 8'hFF.
REQ-027 Release bounce: in HELD, sw[8] low for 2 cycles then high -> inport[8] stays 1 and no second readyPulse occurs.
REQ-028 Reset mid-ARM: assert nReset=0 at edge 5 of a press -> inport=0 and readyPulse=0 immediately; after release with sw[8] held high, readyPulse appears 7 edges later.
REQ-029 INPORT_DEBOUNCE_EN undefined: sw[8] rises at edge 0 -> inport[8]=1 and readyPulse=1 at edge 3; a 1-cycle raw glitch produces a pulse.

Source files
------------

// File: rtl/inport_conditioner.sv
// Switch input conditioner: 2-flop synchroniser, optional ready debounce
// (macro INPORT_DEBOUNCE_EN), data capture/freeze on ready and a one-cycle readyPulse.
module inport_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       nReset,
  input  logic [8:0] sw,
  output logic [8:0] inport,
  output logic       readyPulse
);

  typedef enum logic [1:0] {IDLE, ARM, HELD, DISARM} state_t;

  logic [8:0] sync1_q, syncSw_q;
  logic [7:0] data_q;
  logic       ready_q, pulse_q;
  state_t     state_q, state_d;
  logic       rdy;

  assign rdy = syncSw_q[8];

`ifdef INPORT_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronised ready disagrees with the accepted level.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE:   if (rdy) state_d = ARM;
      ARM: begin
        if (!rdy)                  state_d = IDLE;
        else if (cnt_q == CNT_LAST) state_d = HELD;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      HELD:   if (!rdy) state_d = DISARM;
      DISARM: begin
        if (rdy)                   state_d = HELD;
        else if (cnt_q == CNT_LAST) state_d = IDLE;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  logic unused_params;
  assign unused_params = (DEBOUNCE_CYCLES > 0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rdy)  state_d = HELD;
      HELD:    if (!rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sync1_q  <= '0;
      syncSw_q <= '0;
      state_q  <= IDLE;
      data_q   <= '0;
      ready_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= sw;
      syncSw_q <= sync1_q;
      state_q  <= state_d;
      // Data tracks while not accepted; the last update is the capture on the HELD entry edge.
      if (state_q == IDLE || state_q == ARM) data_q <= syncSw_q[7:0];
      ready_q  <= (state_d == HELD) || (state_d == DISARM);
      pulse_q  <= (state_d == HELD) && (state_q == IDLE || state_q == ARM);
    end
  end

  assign inport     = {ready_q, data_q};
  assign readyPulse = pulse_q;

endmodule

// File: tb/tb_inport_conditioner.sv
// Scoreboard bench for inport_conditioner: run-length reference model feeds an
// expectation queue, a negedge monitor compares; directed scenarios plus random switch traffic.
module tb_inport_conditioner;
  localparam int D = 4;
`ifdef INPORT_DEBOUNCE_EN
  localparam int T   = D + 1;
  localparam int LAT = D + 3;
`else
  localparam int T   = 1;
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       nReset = 1'b0;
  logic [8:0] sw = '0;
  logic [8:0] inport;
  logic       readyPulse;
  int checks = 0;
  int failures = 0;

  inport_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .nReset(nReset), .sw(sw), .inport(inport), .readyPulse(readyPulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: accepted ready level changes once the synchronised value has
  // disagreed with it for T consecutive samples; data follows while not accepted.
  logic [9:0] expq[$];
  logic [8:0] m1, m2;
  logic       mr, mp;
  logic [7:0] md;
  int         run;

  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      m1 = '0; m2 = '0; mr = 1'b0; md = '0; run = 0;
      expq.delete();
    end else begin
      mp = 1'b0;
      if (!mr) md = m2[7:0];
      if (m2[8] != mr) begin
        run++;
        if (run >= T) begin
          mr  = m2[8];
          run = 0;
          mp  = mr;
        end
      end else run = 0;
      m2 = m1;
      m1 = sw;
      expq.push_back({mr, md, mp});
    end
  end

  logic [9:0] e;
  logic       prevp = 1'b0;
  always @(negedge clk) begin
    if (!nReset) begin
      chk("reset_state", {22'h0, inport, readyPulse}, 32'h0);
      prevp = 1'b0;
    end else if (expq.size() == 0) begin
      checks++; failures++;
      $display("FAIL sb_empty: got no expectation expected one at %0t", $time);
    end else begin
      e = expq.pop_front();
      chk("scoreboard", {22'h0, inport, readyPulse}, {22'h0, e});
      chk("no_back2back", {31'h0, prevp & readyPulse}, 32'h0);
      prevp = readyPulse;
    end
  end

  // All stimulus changes land 2 time units after a rising edge.
  task automatic hold(input logic [8:0] v, input int n);
    sw = v;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset(input int n);
    nReset = 1'b0;
    #1 chk("reset_async", {22'h0, inport, readyPulse}, 32'h0);
    repeat (n) @(negedge clk);
    #2 nReset = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic press_latency(input logic [7:0] d);
    int k;
    hold({1'b0, d}, 2 * D + 8);
    sw = {1'b1, d};
    k = 0;
    for (int i = 1; i <= LAT + 4; i++) begin
      @(posedge clk); #1;
      if (readyPulse) begin k = i; break; end
      #1;
    end
    chk("press_latency", k, LAT);
    chk("press_inport", {23'h0, inport}, {23'h0, 1'b1, d});
    @(posedge clk); #1;
    chk("pulse_width", {31'h0, readyPulse}, 32'h0);
    #1;
  endtask

  task automatic freeze_test();
    int k;
    press_latency(8'h3C);
    hold({1'b1, 8'hFF}, 3);
    chk("freeze_held", {24'h0, inport[7:0]}, 32'h3C);
    sw = {1'b0, 8'hFF};
    for (k = 1; k < LAT; k++) begin @(posedge clk); #2; end
    @(posedge clk); #1;
    chk("release_ready", {31'h0, inport[8]}, 32'h0);
    chk("release_data_frozen", {24'h0, inport[7:0]}, 32'h3C);
    @(posedge clk); #1;
    chk("release_follow", {24'h0, inport[7:0]}, 32'hFF);
    #1;
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    #2 nReset = 1'b1;
    @(posedge clk); #2;

    press_latency(8'hA5);
    hold(9'h011, 2 * D + 8);
    // Bounce pattern on ready
    hold(9'h111, 3); hold(9'h011, 2); hold(9'h111, 2); hold(9'h011, 2 * D + 8);
    freeze_test();
    // Release bounce while accepted
    press_latency(8'h5A);
    hold(9'h05A, 2); hold(9'h15A, 2 * D + 4);
    // Reset in the middle of arming, then switch held through reset release
    hold(9'h077, 2 * D + 8);
    hold(9'h177, 5);
    do_reset(2);
    hold(9'h177, 2 * D + 8);
    // Single-cycle raw glitch
    hold(9'h042, 2 * D + 8); hold(9'h142, 1); hold(9'h042, 2 * D + 8);

    repeat (400) begin
      logic [8:0] v;
      int len;
      v   = 9'($urandom);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(D + 2, 3 * D + 6) : $urandom_range(1, D + 1);
      if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
      else if ($urandom_range(0, 2) == 0) begin
        hold(v, len / 2 + 1);
        hold({v[8], 8'($urandom)}, len / 2 + 1);
      end else hold(v, len);
    end
    hold(9'h000, 3 * D + 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
